// File: rtl/demux1to4_buf.sv
// demux1to4_buf: steers one valid/ready word into one of four held lanes.
// Define DEMUX_BCAST_EN to let in_bcast load all four lanes at once.
module demux1to4_buf #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_bcast,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic               busy
);

  logic [3:0][WIDTH-1:0] data_q;
  logic [3:0]            full_q;
  logic [3:0]            lane_free;
  logic [3:0]            sel_oh;
  logic [3:0]            fill_mask;
  logic [3:0]            fill;
  logic [3:0]            drain;
  logic                  accept;

  assign lane_free = ~full_q | out_ready;
  assign sel_oh    = 4'b0001 << in_sel;

`ifdef DEMUX_BCAST_EN
  // Broadcast needs every lane free; otherwise only the selected one.
  always_comb begin
    fill_mask = sel_oh;
    in_ready  = lane_free[in_sel];
    if (in_bcast) begin
      fill_mask = 4'b1111;
      in_ready  = &lane_free;
    end
  end
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;

  // Only the selected lane decides acceptance.
  always_comb begin
    fill_mask = sel_oh;
    in_ready  = lane_free[in_sel];
  end
`endif

  assign accept = in_valid && in_ready;
  assign fill   = accept ? fill_mask : 4'b0000;
  assign drain  = full_q & out_ready;

  // Per-lane holding register: fill wins over drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      full_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fill[i]) begin
          data_q[i] <= in_data;
          full_q[i] <= 1'b1;
        end else if (drain[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = full_q;
  assign busy      = |full_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf: directed scenarios plus a lane scoreboard.
// Build with DEMUX_BCAST_EN to cover the broadcast path.
module tb_demux1to4_buf;

  localparam int W = 32;

  logic           clk;
  logic           reset_n;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_bcast;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic           busy;

  int checks;
  int errors;

  logic [W-1:0] sbq [4][$];

  demux1to4_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  // Scoreboard: pop on drain, then push on accepted input.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          checks++;
          if (sbq[i].size() == 0) begin
            errors++;
            $display("FAIL sb_lane%0d: drained %h, expected none", i, lane(i));
          end else begin
            logic [W-1:0] e;
            e = sbq[i].pop_front();
            if (lane(i) !== e) begin
              errors++;
              $display("FAIL sb_lane%0d: got %h, expected %h", i, lane(i), e);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 4; i++) begin
`ifdef DEMUX_BCAST_EN
          if (in_bcast || in_sel == i[1:0]) sbq[i].push_back(in_data);
`else
          if (in_sel == i[1:0]) sbq[i].push_back(in_data);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_init: valid=%b busy=%b data=%h, expected 0", out_valid, busy, out_data);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 1", in_ready);
    end
    drive(1'b1, 2'd1, 32'h1111_0001);
    tick();
    drive(1'b1, 2'd2, 32'h2222_0002);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0110) begin
      errors++;
      $display("FAIL reset_prefill: got %b, expected 0110", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_async: valid=%b busy=%b data=%h, expected 0", out_valid, busy, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, expected 1/0000", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_single_steer();
    out_ready = 4'b0000;
    drive(1'b1, 2'd2, 32'hDEAD_BEEF);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 4'b0100 || lane(2) !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL steer_hold%0d: valid=%b lane2=%h, expected 0100/deadbeef", k, out_valid, lane(2));
      end
      if (k < 5) tick();
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL steer_drain: valid=%b busy=%b, expected 0000/0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd1, 32'h11);
    tick();
    drive(1'b1, 2'd1, 32'h22);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: ready=%b, expected 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || lane(1) !== 32'h11) begin
      errors++;
      $display("FAIL bp_hold: ready=%b lane1=%h, expected 0/11", in_ready, lane(1));
    end
    out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ready=%b, expected 1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    checks++;
    if (lane(1) !== 32'h22 || out_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_refill: lane1=%h valid=%b, expected 22/1", lane(1), out_valid[1]);
    end
    drain_all();
  endtask

  task automatic test_streaming();
    out_ready = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 2'd3, W'(k));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready%0d: got %b, expected 1", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid[3] !== 1'b1 || lane(3) !== W'(k)) begin
        errors++;
        $display("FAIL stream_word%0d: valid=%b lane3=%h, expected 1/%h", k, out_valid[3], lane(3), W'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL stream_empty: valid3=%b, expected 0", out_valid[3]);
    end
  endtask

  task automatic test_independence();
    drive(1'b1, 2'd0, 32'h55);
    tick();
    drive(1'b1, 2'd1, 32'hA5);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL indep_ready: got %b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (lane(1) !== 32'hA5 || lane(0) !== 32'h55 || out_valid !== 4'b0011) begin
      errors++;
      $display("FAIL indep_lanes: l0=%h l1=%h valid=%b, expected 55/a5/0011", lane(0), lane(1), out_valid);
    end
    drain_all();
  endtask

`ifdef DEMUX_BCAST_EN
  task automatic test_bcast();
    drive(1'b1, 2'd3, 32'h33);
    tick();
    in_bcast = 1'b1;
    drive(1'b1, 2'd0, 32'h77);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bcast_stall: ready=%b, expected 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b1000 || lane(3) !== 32'h33) begin
      errors++;
      $display("FAIL bcast_hold: valid=%b lane3=%h, expected 1000/33", out_valid, lane(3));
    end
    out_ready = 4'b1000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bcast_release: ready=%b, expected 1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b1111 || out_data !== {4{32'h77}}) begin
      errors++;
      $display("FAIL bcast_fill: valid=%b data=%h, expected 1111/77x4", out_valid, out_data);
    end
    drain_all();
  endtask
`else
  task automatic test_bcast_ignored();
    in_bcast = 1'b1;
    drive(1'b1, 2'd0, 32'h77);
    tick();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    checks++;
    if (out_valid !== 4'b0001 || lane(0) !== 32'h77) begin
      errors++;
      $display("FAIL bcast_ignored: valid=%b lane0=%h, expected 0001/77", out_valid, lane(0));
    end
    drain_all();
  endtask
`endif

  task automatic test_back_to_back();
    logic acc;
    drive(1'b1, 2'($urandom_range(0, 3)), $urandom);
    for (int c = 0; c < 400; c++) begin
      out_ready = 4'($urandom);
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc || !in_valid)
        drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom);
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b busy=%b, expected 0000/0", out_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL b2b_queue%0d: %0d words left, expected 0", i, sbq[i].size());
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single_steer();
    test_backpressure();
    test_streaming();
    test_independence();
`ifdef DEMUX_BCAST_EN
    test_bcast();
`else
    test_bcast_ignored();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
